// File: rtl/instruction_loader.sv
// instruction_loader: boot-time program loader.
// Packs a byte stream (valid/ready) big-endian into 32-bit words, writes them
// to consecutive instruction-memory word addresses starting at BASE_ADDR, and
// holds the fetch stage frozen (pcWrite/ifIdWrite) until the program is in.
// Optional feature: define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing
// 8-bit additive checksum byte before releasing the pipeline (CHECK/ERROR).
// All outputs are flops loaded from the next-state decode, so they are stable
// well before the negedge at which the fetch stage samples them.
module instruction_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_resetN,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_programLength,
  input  logic [7:0]            i_byteIn,
  input  logic                  i_byteValid,
  output logic                  o_byteReady,
  output logic                  o_memWriteEnable,
  output logic [31:0]           o_memAddress,
  output logic [31:0]           o_memData,
  output logic                  o_pcWrite,
  output logic                  o_ifIdWrite,
  output logic                  o_loading,
  output logic                  o_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECEIVE = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_FINAL = S_CHECK;
`else
  localparam logic [2:0] S_FINAL = S_RUN;
`endif

  // Largest legal program: 2^ADDR_WIDTH words.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]          r_state;
  logic [1:0]          r_byteCnt;
  logic [ADDR_WIDTH:0] r_index;
  logic [ADDR_WIDTH:0] r_len;
  logic [31:0]         r_word;
  logic [7:0]          r_csum;

  logic [2:0]          w_next;
  logic                w_fire;
  logic                w_startOk;
  logic [ADDR_WIDTH:0] w_lenClamp;
  logic [ADDR_WIDTH:0] w_idxInc;
  logic [31:0]         w_asm;

  assign w_fire     = i_byteValid & o_byteReady;
  assign w_startOk  = i_start & ((r_state == S_IDLE) | (r_state == S_RUN) |
                                 (r_state == S_ERROR));
  assign w_lenClamp = (i_programLength > MAX_LEN) ? MAX_LEN : i_programLength;
  assign w_idxInc   = r_index + 1'b1;

  // Assembly register with the incoming byte merged in at its big-endian slot,
  // so the 4th byte is already part of the word written in WRITE.
  always_comb begin
    w_asm = r_word;
    case (r_byteCnt)
      2'd0: w_asm[31:24] = i_byteIn;
      2'd1: w_asm[23:16] = i_byteIn;
      2'd2: w_asm[15:8]  = i_byteIn;
      default: w_asm[7:0] = i_byteIn;
    endcase
  end

  // Next-state decode of the load session.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_startOk) w_next = (w_lenClamp != '0) ? S_RECEIVE : S_FINAL;
      end
      S_RECEIVE: begin
        if (w_fire && (r_byteCnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_idxInc == r_len) ? S_FINAL : S_RECEIVE;
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_fire) w_next = (i_byteIn == r_csum) ? S_RUN : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Session state, datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state          <= S_IDLE;
      r_byteCnt        <= '0;
      r_index          <= '0;
      r_len            <= '0;
      r_word           <= '0;
      r_csum           <= '0;
      o_byteReady      <= 1'b0;
      o_memWriteEnable <= 1'b0;
      o_memAddress     <= BASE_ADDR;
      o_memData        <= '0;
      o_pcWrite        <= 1'b0;
      o_ifIdWrite      <= 1'b0;
      o_loading        <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_startOk) begin
        r_len     <= w_lenClamp;
        r_index   <= '0;
        r_csum    <= '0;
        r_byteCnt <= '0;
      end
      if ((r_state == S_RECEIVE) && w_fire) begin
        r_word    <= w_asm;
        r_byteCnt <= r_byteCnt + 2'd1;
        r_csum    <= r_csum + i_byteIn;
      end
      if (r_state == S_WRITE) r_index <= w_idxInc;

      o_byteReady      <= (w_next == S_RECEIVE) | (w_next == S_CHECK);
      o_memWriteEnable <= (w_next == S_WRITE);
      if (w_next == S_WRITE) begin
        // Byte address wraps modulo 2^32.
        o_memAddress <= BASE_ADDR + (32'(r_index) << 2);
        o_memData    <= w_asm;
      end
      o_pcWrite   <= (w_next == S_RUN);
      o_ifIdWrite <= (w_next == S_RUN);
      o_loading   <= (w_next == S_RECEIVE) | (w_next == S_WRITE) |
                     (w_next == S_CHECK);
      o_done      <= (w_next == S_RUN) && (r_state != S_RUN);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every memory write strobe.
module tb_instruction_loader;
  localparam int          AW   = 3;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        i_resetN = 1'b0, i_start = 1'b0, i_byteValid = 1'b0;
  logic [AW:0] i_programLength = '0;
  logic [7:0]  i_byteIn = '0;
  logic        o_byteReady, o_memWriteEnable, o_pcWrite, o_ifIdWrite, o_loading, o_done;
  logic [31:0] o_memAddress, o_memData;

  instruction_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_resetN(i_resetN), .i_start(i_start),
    .i_programLength(i_programLength), .i_byteIn(i_byteIn),
    .i_byteValid(i_byteValid), .o_byteReady(o_byteReady),
    .o_memWriteEnable(o_memWriteEnable), .o_memAddress(o_memAddress),
    .o_memData(o_memData), .o_pcWrite(o_pcWrite), .o_ifIdWrite(o_ifIdWrite),
    .o_loading(o_loading), .o_done(o_done));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t        exp_q[$];
  wr_t        mon_e;
  int         wr_cycles[$];
  logic [7:0] pb[$];
  int         checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cycle = -1;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) if (mon_en) begin
    if (o_memWriteEnable) begin
      wr_cycles.push_back(cyc);
      chk("byteReady_low_in_write", {31'b0, o_byteReady}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 o_memAddress, o_memData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", o_memAddress, mon_e.a);
        chk("wr_data", o_memData, mon_e.d);
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cycle = cyc;
      chk("enables_with_done", {30'b0, o_pcWrite, o_ifIdWrite}, 32'h3);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_resetN = 1'b0; i_start = 1'b0; i_byteValid = 1'b0;
    tick();
    chk("rst_outputs", {24'b0, o_byteReady, o_memWriteEnable, o_pcWrite, o_ifIdWrite,
                        o_loading, o_done, 2'b0}, 32'h0);
    chk("rst_addr", o_memAddress, BASE);
    chk("rst_data", o_memData, 32'h0);
    i_resetN = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    i_byteIn = b; i_byteValid = 1'b1;
    while (!o_byteReady && t < 50) begin tick(); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL byte_timeout: got byteReady=0 for 50 cycles expected 1");
    end
    tick();
    i_byteValid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic start_load(input int len);
    i_start = 1'b1; i_programLength = len[AW:0];
    tick();
    i_start = 1'b0;
  endtask

  // Reference: n = min(len, 2^AW) words; word w = bytes 4w..4w+3 big-endian
  // at BASE + 4w. gm: 0 full rate, 1 one idle cycle per byte, 2 random gaps.
  task automatic run_load(input int len, input int gm, input bit good_csum);
    int n, p, wc, st, t;
    logic [7:0] s;
    bit expect_run;
    n = (len > (1 << AW)) ? (1 << AW) : len;
    s = 8'h00;
    for (int w = 0; w < n; w++) begin
      wr_t e;
      e.a = BASE + 32'(4 * w);
      e.d = {pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]};
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) s = s + pb[4*w+k];
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    expect_run = good_csum;
`else
    expect_run = 1'b1;
`endif
    p = done_cnt; wc = wr_cycles.size();
    start_load(len);
    st = cyc;
    if (n > 0) chk("after_start_frozen", {30'b0, o_loading, o_pcWrite}, 32'h2);
    for (int i = 0; i < 4 * n; i++)
      send_byte(pb[i], (gm == 0) ? 0 : (gm == 1) ? 1 : $urandom_range(0, 2));
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(good_csum ? s : s + 8'd1, 0);
`endif
    t = 0;
    while (done_cnt == p && t < 40) begin tick(); t++; end
    chk("done_seen", {31'b0, (done_cnt != p)}, {31'b0, expect_run});
    chk("all_writes_seen", exp_q.size(), 32'h0);
    chk("write_count", wr_cycles.size() - wc, n);
    if (expect_run) begin
`ifndef INSTRUCTION_LOADER_CHECKSUM_EN
      if (n > 0) chk("done_after_last_write", done_cycle, wr_cycles[wr_cycles.size()-1] + 1);
      else       chk("done_next_edge_len0", done_cycle, st);
`endif
      tick();
      chk("run_state", {29'b0, o_done, o_pcWrite, o_ifIdWrite, o_loading}, 32'h6);
    end else begin
      chk("error_frozen", {29'b0, o_pcWrite, o_ifIdWrite, o_loading, o_byteReady}, 32'h0);
    end
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    // Idle after reset: frozen, nothing written.
    tick(10);
    chk("idle_frozen", {29'b0, o_pcWrite, o_ifIdWrite, o_byteReady}, 32'h0);

    // Full-rate 2-word load, writes 5 cycles apart.
    pb = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(2, 0, 1'b1);
    chk("write_spacing", wr_cycles[wr_cycles.size()-1] - wr_cycles[wr_cycles.size()-2], 32'd5);

    // Same load with byteValid toggled; also exercises start from RUN.
    run_load(2, 1, 1'b1);

    // Reset after 2 bytes of word 1: partial word discarded.
    start_load(2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, 1'b1);

    // Length 0 from IDLE.
    do_reset();
    pb.delete();
    run_load(0, 0, 1'b1);

    // Randomized loads with random stall gaps.
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 5);
      pb.delete();
      for (int i = 0; i < 4 * len; i++) pb.push_back(8'($urandom));
      run_load(len, 2, 1'b1);
    end

    // Over-long length clamps to 2^AW words.
    pb.delete();
    for (int i = 0; i < 4 * (1 << AW); i++) pb.push_back(8'($urandom));
    run_load(12, 0, 1'b1);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    // Checksum 0A accepted, 0B rejected into ERROR.
    pb = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 1'b1);
    run_load(1, 0, 1'b0);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words and writes them to consecutive word addresses. It holds the fetch stage frozen via `pcWrite`/`ifIdWrite` until the whole program is written, then releases the pipeline.

## Interface
- `ADDR_WIDTH`, default 8: word-index width; maximum program is 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h0: byte address of the first written word. Must match the fetch stage PC start value.

- `clk`  in  1  single clock; all state updates on posedge.
- `resetN`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load session.
- `programLength`  in  ADDR_WIDTH+1  word count, latched on accepted `start`.
- `byteIn`  in  8  stream data.
- `byteValid`  in  1  stream data valid.
- `byteReady`  out  1  loader can accept a byte this cycle.
- `memWriteEnable`  out  1  one-cycle instruction-memory write strobe.
- `memAddress`  out  32  byte address of the write.
- `memData`  out  32  instruction word.
- `pcWrite`  out  1  fetch PC advance enable.
- `ifIdWrite`  out  1  IF/ID register enable.
- `loading`  out  1  high while a session is in progress.
- `done`  out  1  one-cycle pulse on entering RUN.

## Operation
- States: IDLE, RECEIVE, WRITE, CHECK (only with the macro), RUN, ERROR.
- Reset, from any state: enter IDLE. Clear the byte counter, word index, assembly register and checksum.
- Reset outputs: `byteReady`=0, `memWriteEnable`=0, `memAddress`=BASE_ADDR, `memData`=0, `pcWrite`=0, `ifIdWrite`=0, `loading`=0, `done`=0.
- IDLE, RUN and ERROR accept `start`; RECEIVE, WRITE and CHECK ignore it.
  - On accepted `start` with `programLength`≠0: latch the length, clear word index and checksum, go to RECEIVE.
  - On accepted `start` with `programLength`=0: go to CHECK (with the macro) or RUN (without it).
- RECEIVE:
  - `byteReady`=1; a byte transfers when `byteValid && byteReady` at posedge.
  - Byte k of a word (k=0..3) goes to bits [31-8k -: 8].
  - After the 4th byte, go to WRITE.
- WRITE lasts exactly one cycle:
  - `byteReady`=0, `memWriteEnable`=1, `memData`=assembled word, `memAddress`=BASE_ADDR + 4×index (32-bit, wraps modulo 2^32).
  - Then increment the index. If index equals the latched length, go to CHECK or RUN; otherwise return to RECEIVE.
- RUN: `pcWrite`=`ifIdWrite`=1, `loading`=0. Both enables are 0 in every other state.
- ERROR: pipeline stays frozen. Only reset or a new `start` leaves it.
- `loading`=1 in RECEIVE, WRITE and CHECK.
- A length above 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.

## Timing
- Byte accepted at edge N: the assembly register updates at N.
- 4th byte at edge N: WRITE is the cycle N→N+1, and `memWriteEnable` is high for exactly that cycle.
- Peak throughput: 5 cycles per word (4 byte cycles plus 1 write cycle).
- From the last WRITE, RUN is entered at the next edge. `done` pulses that cycle; `pcWrite`/`ifIdWrite` rise the same cycle.
- All outputs are registered and stable before the negedge at which the fetch stage samples them.
- `start` while in RUN: enables drop at the next edge. An instruction already in IF/ID is held, not flushed.
- Stalled stream (`byteValid`=0): remain in RECEIVE indefinitely with no timeout.
- Reset mid-word or mid-WRITE: the partial word is discarded. A write strobe asserted in the reset cycle is deasserted at the reset edge.

## Configuration
- `INSTRUCTION_LOADER_CHECKSUM_EN` defined:
  - After the last word, CHECK accepts one extra byte via the same handshake.
  - If it equals the 8-bit sum mod 256 of all program bytes, go to RUN; otherwise go to ERROR.
  - CHECK with `programLength`=0 expects the byte 8'h00.
- Undefined: no CHECK state and no ERROR state. The last WRITE goes directly to RUN, and no extra byte is consumed.

## Test plan
- Reset then idle 10 cycles → `pcWrite`=`ifIdWrite`=0, `byteReady`=0, `memWriteEnable` never high.
- `start`, length 2, bytes 12 34 56 78 9A BC DE F0 at full rate → writes (0x0, 0x12345678) then (0x4, 0x9ABCDEF0), one cycle each, 5 cycles apart. `done` pulse, then enables=1.
- Same load with `byteValid` toggled every other cycle → identical writes; `byteReady` is 0 in WRITE cycles.
- `resetN` low after 2 bytes of word 1, then a fresh 1-word load of AABBCCDD → single write (0x0, 0xAABBCCDD); no stale bytes.
- `start` length 0 → RUN at the next edge with no writes (macro off). With the macro on, RUN follows checksum byte 00.
- Macro on, length 1, bytes 01 02 03 04, checksum 0A → RUN. Same load with checksum 0B → ERROR with enables held 0.
